mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning load/store data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning byte-address width in bits.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_arst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_mem_access  in  1  current memory-stage instruction is a load or store.
REQ-006 SHALL have port i_mem_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port i_func3  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 SHALL have port i_alu_result  in  ADDR_WIDTH  effective byte address.
REQ-009 SHALL have port i_write_data  in  DATA_WIDTH  store data, right-aligned.
REQ-010 SHALL have port o_req_valid  out  1  data-cache request valid.
REQ-011 SHALL have port i_req_ready  in  1  data cache accepts the request.
REQ-012 SHALL have port o_req_we / o_req_addr / o_req_wdata / o_req_be  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  request write flag, doubleword-aligned address, lane-shifted data, byte enables.
REQ-013 SHALL have port i_resp_valid / i_resp_rdata  in  1 / DATA_WIDTH  load response and its raw doubleword.
REQ-014 SHALL have port o_stall_mem  out  1  freezes the execute-to-memory pipeline register.
REQ-015 SHALL have port o_load_data  out  DATA_WIDTH  extracted, extended load result.
REQ-016 SHALL have port o_misalign / o_cause  out  1 / 4  misaligned-access exception and cause code.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-018 SHALL detect misalignment combinationally: h needs addr[0]=0, w addr[1:0]=0, d addr[2:0]=0; func3 111 treated as d.
REQ-019 IDLE, i_mem_access=1, aligned: next state REQ; o_stall_mem=1 that same cycle.
REQ-020 IDLE, i_mem_access=1, misaligned: no request, stay IDLE, o_stall_mem=0, o_misalign=1, o_cause=4 (load) or 6 (store), all in the same cycle.
REQ-021 REQ: o_req_valid=1 with stable fields until i_req_ready=1; store -> DONE, load -> WAIT.
REQ-022 WAIT: hold until i_resp_valid=1; register extracted data; -> DONE.
REQ-023 DONE: o_stall_mem=0 for exactly one cycle, o_load_data valid, -> IDLE; no new request is issued from DONE.
REQ-024 o_stall_mem SHALL be 1 in REQ and WAIT, and in IDLE when REQ-019 applies; 0 otherwise.
REQ-025 o_req_addr SHALL be i_alu_result with bits [2:0] cleared; o_req_be = size mask shifted left by addr[2:0]; o_req_wdata = i_write_data shifted left by 8*addr[2:0].
REQ-026 Load extraction SHALL shift i_resp_rdata right by 8*addr[2:0], then sign-extend (b/h/w) or zero-extend (bu/hu/wu) to DATA_WIDTH.
REQ-027 i_resp_valid outside WAIT SHALL be ignored; i_req_ready outside REQ SHALL be ignored.
REQ-028 Minimum latency: store 2 stall cycles (IDLE, REQ) with ready=1; load 3 stall cycles with ready=1 and response the cycle after acceptance.

Reset
REQ-029 i_arst_n=0 at a clock edge SHALL force IDLE, o_load_data=0, all other registered state 0.
REQ-030 Reset during REQ or WAIT SHALL abandon the access; o_req_valid=0 from the next cycle; a late response is ignored.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, func3 size encodings, and cause constants 4 and 6.
REQ-032 One sub-module load_extract (shift + extend, combinational) is natural; FSM and store alignment stay in mem_lsu.

Verification
REQ-033 sd 0x1122334455667788 to 0x1000, ready=1 -> one request, be=0xFF, addr 0x1000, stall 2 cycles then 0.
REQ-034 lb from 0x2003, rdata 0x00000000_80000000 -> o_load_data 0xFFFFFFFFFFFFFF80; lbu same -> 0x80.
REQ-035 lw from 0x2002 -> o_misalign=1, o_cause=4, no o_req_valid, o_stall_mem=0.
REQ-036 sh 0xABCD to 0x3006, ready low 3 cycles -> request held stable, be=0xC0, wdata[63:48]=0xABCD, stall held.
REQ-037 Reset asserted in WAIT, response arrives next cycle -> state IDLE, o_load_data=0, no DONE pulse.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Holds the FSM encoding, access-size codes, exception causes and size helpers.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

  // Size is carried in func3[1:0]; 111 falls into the doubleword case.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_load_extract.sv
// Right-aligns the addressed bytes of a raw doubleword and sign/zero extends
// them according to the access size.
module load_extract
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [2:0]            i_offset,
  input  logic [2:0]            i_func3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_func3)
      F3_B:  o_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_H:  o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:  o_data = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_BU: o_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_HU: o_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      F3_WU: o_data = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: misalignment check, request issue to the data
// cache with valid/ready, response capture and pipeline stall control.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    i_mem_access,
  input  logic                    i_mem_we,
  input  logic [2:0]              i_func3,
  input  logic [ADDR_WIDTH-1:0]   i_alu_result,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  output logic                    o_req_valid,
  input  logic                    i_req_ready,
  output logic                    o_req_we,
  output logic [ADDR_WIDTH-1:0]   o_req_addr,
  output logic [DATA_WIDTH-1:0]   o_req_wdata,
  output logic [DATA_WIDTH/8-1:0] o_req_be,
  input  logic                    i_resp_valid,
  input  logic [DATA_WIDTH-1:0]   i_resp_rdata,
  output logic                    o_stall_mem,
  output logic [DATA_WIDTH-1:0]   o_load_data,
  output logic                    o_misalign,
  output logic [3:0]              o_cause,
  output logic [1:0]              o_dbg_state
);

  localparam int BE_W = DATA_WIDTH / 8;

  lsu_state_e            r_state;
  logic                  r_we;
  logic [2:0]            r_func3;
  logic [2:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_load_data;

  logic                  w_mis;
  logic                  w_idle_access;
  logic                  w_start;
  logic [BE_W-1:0]       w_mask;
  logic [DATA_WIDTH-1:0] w_extracted;

  assign w_mis         = is_misaligned(i_func3[1:0], i_alu_result[2:0]);
  assign w_idle_access = (r_state == ST_IDLE) && i_mem_access;
  assign w_start       = w_idle_access && !w_mis;
  assign w_mask        = BE_W'(size_mask(i_func3[1:0]));

  load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_load_extract (
    .i_rdata  (i_resp_rdata),
    .i_offset (r_off),
    .i_func3  (r_func3),
    .o_data   (w_extracted)
  );

  // Request fields are captured on entry to REQ so they stay stable while the
  // cache back-pressures, independent of the pipeline inputs.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_func3     <= 3'b000;
      r_off       <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_we    <= i_mem_we;
            r_func3 <= i_func3;
            r_off   <= i_alu_result[2:0];
            r_addr  <= {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
            r_wdata <= i_write_data << {i_alu_result[2:0], 3'b000};
            r_be    <= w_mask << i_alu_result[2:0];
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_req_ready) r_state <= r_we ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (i_resp_valid) begin
            r_load_data <= w_extracted;
            r_state     <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake: a request transfers on a rising edge where o_req_valid and
  // i_req_ready are both high; valid never drops and fields never change
  // before that edge. i_resp_valid is a one-cycle strobe sampled only in WAIT.
  assign o_req_valid = (r_state == ST_REQ);
  assign o_req_we    = r_we;
  assign o_req_addr  = r_addr;
  assign o_req_wdata = r_wdata;
  assign o_req_be    = r_be;
  assign o_load_data = r_load_data;
  assign o_dbg_state = r_state;

  assign o_stall_mem = (r_state == ST_REQ) || (r_state == ST_WAIT) || w_start;
  assign o_misalign  = w_idle_access && w_mis;
  assign o_cause     = !o_misalign ? 4'd0 :
                       (i_mem_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN);

endmodule
